// File: rtl/frame_cfg_loader.sv
// frame_cfg_loader: receives 0xA5-headed configuration frames from the UART RX
// byte stream, assembles them in shadow registers and commits them to the
// timing buses only when the XOR checksum matches. Answers 0x72 queries and
// every frame outcome with ACK (0x06) / NAK (0x15) on the response strobe.
//
// Handshake: rx_valid and resp_valid are one-cycle strobes with no back-pressure.
// The data that goes with a strobe is valid only in the cycle the strobe is high.
// A byte that arrives while the checksum is being evaluated is dropped.
module frame_cfg_loader #(
    parameter int N_CH        = 8,
    parameter int TW          = 32,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [N_CH*TW-1:0]   del_bus,
    output logic [N_CH*TW-1:0]   dur_bus,
    output logic [N_CH*8-1:0]    res_bus,
    output logic [7:0]           thhv,
    output logic                 cfg_valid,
    output logic                 cfg_update,
    output logic [7:0]           resp_data,
    output logic                 resp_valid,
    output logic [7:0]           err_cnt,
    output logic [1:0]           dbg_state
);

    localparam int BPT    = TW / 8;
    localparam int STRIDE = 2 * BPT + 1;
    localparam int L      = N_CH * STRIDE + 1;
    localparam int IDXW   = $clog2(L + 1);
    localparam int CHW    = $clog2(N_CH + 1);
    localparam int OFFW   = $clog2(STRIDE);
    localparam int CNTW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(L);
    localparam logic [CHW-1:0]  LAST_CH  = CHW'(N_CH);
    localparam logic [OFFW-1:0] OFF_DUR  = OFFW'(BPT);
    localparam logic [OFFW-1:0] OFF_RES  = OFFW'(2 * BPT);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [7:0] QRY = 8'h72;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [OFFW-1:0]     off_q, off_d;
    logic [7:0]          xor_q, xor_d;
    logic [7:0]          chk_q, chk_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    logic [N_CH*TW-1:0]  del_sh_q, del_sh_d;
    logic [N_CH*TW-1:0]  dur_sh_q, dur_sh_d;
    logic [N_CH*8-1:0]   res_sh_q, res_sh_d;
    logic [7:0]          thhv_sh_q, thhv_sh_d;

    logic [N_CH*TW-1:0]  del_q, del_d;
    logic [N_CH*TW-1:0]  dur_q, dur_d;
    logic [N_CH*8-1:0]   res_q, res_d;
    logic [7:0]          thhv_q, thhv_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                cfg_update_q, cfg_update_d;
    logic [7:0]          resp_data_q, resp_data_d;
    logic                resp_valid_q, resp_valid_d;
    logic [7:0]          err_q, err_d;

    // Next-state, shadow assembly, commit and response logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ch_d         = ch_q;
        off_d        = off_q;
        xor_d        = xor_q;
        chk_d        = chk_q;
        cnt_d        = cnt_q;
        del_sh_d     = del_sh_q;
        dur_sh_d     = dur_sh_q;
        res_sh_d     = res_sh_q;
        thhv_sh_d    = thhv_sh_q;
        del_d        = del_q;
        dur_d        = dur_q;
        res_d        = res_q;
        thhv_d       = thhv_q;
        cfg_valid_d  = cfg_valid_q;
        cfg_update_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == HDR) begin
                        state_d = S_PAYLOAD;
                        idx_d   = '0;
                        ch_d    = '0;
                        off_d   = '0;
                        xor_d   = '0;
                        cnt_d   = '0;
                    end else if (rx_data == QRY) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = cfg_valid_q ? ACK : NAK;
                    end
                end
            end

            S_PAYLOAD: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        // All payload bytes are in; this one is the checksum.
                        chk_d   = rx_data;
                        state_d = S_CHECK;
                    end else begin
                        xor_d = xor_q ^ rx_data;
                        idx_d = idx_q + IDXW'(1);
                        if (ch_q == LAST_CH) begin
                            thhv_sh_d = rx_data;
                        end else begin
                            // Multi-byte fields arrive MSB first, so shift left.
                            for (int k = 0; k < N_CH; k++) begin
                                if (ch_q == CHW'(k)) begin
                                    if (off_q < OFF_DUR) begin
                                        del_sh_d[k*TW +: TW] = (del_sh_q[k*TW +: TW] << 8) | TW'(rx_data);
                                    end else if (off_q < OFF_RES) begin
                                        dur_sh_d[k*TW +: TW] = (dur_sh_q[k*TW +: TW] << 8) | TW'(rx_data);
                                    end else begin
                                        res_sh_d[k*8 +: 8] = rx_data;
                                    end
                                end
                            end
                            if (off_q == OFF_RES) begin
                                off_d = '0;
                                ch_d  = ch_q + CHW'(1);
                            end else begin
                                off_d = off_q + OFFW'(1);
                            end
                        end
                    end
                end else if (cnt_q == CNT_MAX) begin
                    // Sender went quiet mid-frame: drop it and report.
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = NAK;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            S_CHECK: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                if (xor_q == chk_q) begin
                    del_d        = del_sh_q;
                    dur_d        = dur_sh_q;
                    res_d        = res_sh_q;
                    thhv_d       = thhv_sh_q;
                    cfg_valid_d  = 1'b1;
                    cfg_update_d = 1'b1;
                    resp_data_d  = ACK;
                end else begin
                    resp_data_d  = NAK;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, shadow and output registers; everything clears on reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            ch_q         <= '0;
            off_q        <= '0;
            xor_q        <= '0;
            chk_q        <= '0;
            cnt_q        <= '0;
            del_sh_q     <= '0;
            dur_sh_q     <= '0;
            res_sh_q     <= '0;
            thhv_sh_q    <= '0;
            del_q        <= '0;
            dur_q        <= '0;
            res_q        <= '0;
            thhv_q       <= '0;
            cfg_valid_q  <= 1'b0;
            cfg_update_q <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ch_q         <= ch_d;
            off_q        <= off_d;
            xor_q        <= xor_d;
            chk_q        <= chk_d;
            cnt_q        <= cnt_d;
            del_sh_q     <= del_sh_d;
            dur_sh_q     <= dur_sh_d;
            res_sh_q     <= res_sh_d;
            thhv_sh_q    <= thhv_sh_d;
            del_q        <= del_d;
            dur_q        <= dur_d;
            res_q        <= res_d;
            thhv_q       <= thhv_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_update_q <= cfg_update_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
        end
    end

    assign del_bus    = del_q;
    assign dur_bus    = dur_q;
    assign res_bus    = res_q;
    assign thhv       = thhv_q;
    assign cfg_valid  = cfg_valid_q;
    assign cfg_update = cfg_update_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign err_cnt    = err_q;
    assign dbg_state  = state_q;

endmodule
